// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared types and constants for the SD card clock controller
package sd_pkg;

   localparam int                  SD_DIV_W     = 16;
   localparam logic [SD_DIV_W-1:0] SD_DIV_400K  = 16'd124;
   localparam int                  SD_INIT_CLKS = 74;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_INIT     = 2'd1,
      ST_RUN      = 2'd2,
      ST_STOPPING = 2'd3
   } sd_state_t;

endpackage

// File: rtl/sd_clk_ctrl_if.sv
// rtl/sd_clk_ctrl_if.sv - host-side control and card-clock status bundle
interface sd_clk_ctrl_if #(parameter int DIV_W = sd_pkg::SD_DIV_W);

   logic             clk_en;
   logic             div_wr;
   logic [DIV_W-1:0] div_val;
   logic             sd_clk;
   logic             sd_clk_rise;
   logic             sd_clk_fall;
   logic             running;
   logic             div_pending;
   logic [DIV_W-1:0] div_cur;
   logic             init_done;

   modport master (
      output clk_en, div_wr, div_val,
      input  sd_clk, sd_clk_rise, sd_clk_fall, running, div_pending, div_cur, init_done
   );

   modport slave (
      input  clk_en, div_wr, div_val,
      output sd_clk, sd_clk_rise, sd_clk_fall, running, div_pending, div_cur, init_done
   );

endinterface

// File: rtl/sd_clk_div_core.sv
// rtl/sd_clk_div_core.sv - half-period counter, card clock toggle and edge strobes
module sd_clk_div_core #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cnt_en,
   input  logic [DIV_W-1:0] div,
   output logic             sd_clk,
   output logic             rise,
   output logic             fall,
   output logic             fall_now
);

   logic [DIV_W-1:0] cnt;
   logic             tick;

   assign tick     = cnt_en && (cnt == div);
   assign fall_now = tick && sd_clk;

   // Disabled means parked low with the phase count discarded.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt    <= '0;
         sd_clk <= 1'b0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         rise <= tick && !sd_clk;
         fall <= tick && sd_clk;
         if (!cnt_en) begin
            cnt    <= '0;
            sd_clk <= 1'b0;
         end else if (tick) begin
            cnt    <= '0;
            sd_clk <= ~sd_clk;
         end else begin
            cnt <= cnt + DIV_W'(1);
         end
      end
   end

endmodule

// File: rtl/sd_clk_ctrl.sv
// rtl/sd_clk_ctrl.sv - SD card clock sequencer with glitch-free divisor switching
// Optional power-up clock sequence enabled by SD_CLK_INIT_SEQ_EN.
module sd_clk_ctrl
   import sd_pkg::*;
#(
   parameter int               DIV_W    = SD_DIV_W,
   parameter logic [DIV_W-1:0] INIT_DIV = DIV_W'(SD_DIV_400K)
`ifdef SD_CLK_INIT_SEQ_EN
   ,
   parameter int               INIT_CLKS = SD_INIT_CLKS
`endif
) (
   input logic          clk,
   input logic          reset,
   sd_clk_ctrl_if.slave bus
);

   sd_state_t        state;
   logic             running_r;
   logic             sd_clk_r;
   logic             fall_now;
   logic             cnt_en;
   logic             apply;
   logic             pend_flag;
   logic [DIV_W-1:0] pend_val;
   logic [DIV_W-1:0] div_cur_r;

   // A stop request during the low phase cuts it short instead of finishing it.
   assign cnt_en = (state != ST_IDLE) && !(state == ST_RUN && !bus.clk_en && !sd_clk_r);
   assign apply  = pend_flag && ((state == ST_IDLE) ||
                   ((state == ST_RUN || state == ST_STOPPING) && fall_now));

   sd_clk_div_core #(.DIV_W(DIV_W)) u_core (
      .clk      (clk),
      .reset    (reset),
      .cnt_en   (cnt_en),
      .div      (div_cur_r),
      .sd_clk   (sd_clk_r),
      .rise     (bus.sd_clk_rise),
      .fall     (bus.sd_clk_fall),
      .fall_now (fall_now)
   );

`ifdef SD_CLK_INIT_SEQ_EN
   localparam int             ICW       = $clog2(INIT_CLKS + 1);
   localparam logic [ICW-1:0] INIT_LAST = ICW'(INIT_CLKS - 1);
   logic           init_done_r;
   logic [ICW-1:0] init_cnt;
   assign bus.init_done = init_done_r;
`else
   assign bus.init_done = 1'b1;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         running_r <= 1'b0;
`ifdef SD_CLK_INIT_SEQ_EN
         init_done_r <= 1'b0;
         init_cnt    <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: if (bus.clk_en) begin
               running_r <= 1'b1;
`ifdef SD_CLK_INIT_SEQ_EN
               state <= init_done_r ? ST_RUN : ST_INIT;
`else
               state <= ST_RUN;
`endif
            end
`ifdef SD_CLK_INIT_SEQ_EN
            // Falls are counted: each one closes a rise, so the last fall ends the sequence.
            ST_INIT: if (fall_now) begin
               if (init_cnt == INIT_LAST) begin
                  init_done_r <= 1'b1;
                  init_cnt    <= '0;
                  state       <= bus.clk_en ? ST_RUN : ST_IDLE;
                  running_r   <= bus.clk_en;
               end else begin
                  init_cnt <= init_cnt + ICW'(1);
               end
            end
`endif
            ST_RUN: if (!bus.clk_en) begin
               if (sd_clk_r && !fall_now) begin
                  state <= ST_STOPPING;
               end else begin
                  state     <= ST_IDLE;
                  running_r <= 1'b0;
               end
            end
            ST_STOPPING: if (fall_now) begin
               state     <= bus.clk_en ? ST_RUN : ST_IDLE;
               running_r <= bus.clk_en;
            end
            default: begin
               state     <= ST_IDLE;
               running_r <= 1'b0;
            end
         endcase
      end
   end

   // A write landing on the apply cycle queues behind the value being applied.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cur_r <= INIT_DIV;
         pend_val  <= '0;
         pend_flag <= 1'b0;
      end else if (apply) begin
         div_cur_r <= pend_val;
         if (bus.div_wr) begin
            pend_val <= bus.div_val;
         end else begin
            pend_flag <= 1'b0;
         end
      end else if (bus.div_wr) begin
         pend_val  <= bus.div_val;
         pend_flag <= 1'b1;
      end
   end

   assign bus.sd_clk      = sd_clk_r;
   assign bus.running     = running_r;
   assign bus.div_pending = pend_flag;
   assign bus.div_cur     = div_cur_r;

endmodule

// File: tb/tb_sd_clk_ctrl.sv
// tb/tb_sd_clk_ctrl.sv - directed self-checking bench for sd_clk_ctrl
module tb_sd_clk_ctrl;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

`ifdef SD_CLK_INIT_SEQ_EN
   localparam logic EXP_INIT_DONE = 1'b0;
`else
   localparam logic EXP_INIT_DONE = 1'b1;
`endif

   sd_clk_ctrl_if #(.DIV_W(16)) bus ();

   sd_clk_ctrl #(.DIV_W(16), .INIT_DIV(16'd124)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input logic [15:0] d);
      bus.div_wr  = 1'b1;
      bus.div_val = d;
      tick();
      bus.div_wr = 1'b0;
      bus.clk_en = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      reset       = 1'b1;
      bus.clk_en  = 1'b0;
      bus.div_wr  = 1'b0;
      bus.div_val = '0;
      tick();
      tick();
      n_checks++;
      if ({bus.sd_clk, bus.sd_clk_rise, bus.sd_clk_fall, bus.running, bus.div_pending} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_flags got %b want 00000",
                  {bus.sd_clk, bus.sd_clk_rise, bus.sd_clk_fall, bus.running, bus.div_pending});
      end
      n_checks++;
      if (bus.div_cur !== 16'd124) begin
         n_fail++;
         $display("FAIL reset_div_cur got %0d want 124", bus.div_cur);
      end
      n_checks++;
      if (bus.init_done !== EXP_INIT_DONE) begin
         n_fail++;
         $display("FAIL reset_init_done got %b want %b", bus.init_done, EXP_INIT_DONE);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_run();
      logic [2:0] exp;
      bus.div_wr  = 1'b1;
      bus.div_val = 16'd3;
      tick();
      n_checks++;
      if (bus.div_pending !== 1'b1) begin
         n_fail++;
         $display("FAIL run_pending got %b want 1", bus.div_pending);
      end
      bus.div_wr = 1'b0;
      bus.clk_en = 1'b1;
      tick();
      n_checks++;
      if ({bus.div_cur, bus.div_pending, bus.running} !== {16'd3, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL run_start got div=%0d pend=%b run=%b want div=3 pend=0 run=1",
                  bus.div_cur, bus.div_pending, bus.running);
      end
      for (int j = 1; j <= 16; j++) begin
         tick();
         exp = {((j / 4) % 2) == 1, (j % 8) == 4, (j % 8) == 0};
         n_checks++;
         if ({bus.sd_clk, bus.sd_clk_rise, bus.sd_clk_fall} !== exp) begin
            n_fail++;
            $display("FAIL run_wave cycle %0d got clk/rise/fall=%b want %b", j,
                     {bus.sd_clk, bus.sd_clk_rise, bus.sd_clk_fall}, exp);
         end
      end
      bus.clk_en = 1'b0;
      tick();
      n_checks++;
      if ({bus.running, bus.sd_clk} !== 2'b00) begin
         n_fail++;
         $display("FAIL run_stop_low got run/clk=%b want 00", {bus.running, bus.sd_clk});
      end
   endtask

   task automatic test_stop_high();
      start_run(16'd3);
      for (int j = 1; j <= 5; j++) tick();
      bus.clk_en = 1'b0;
      for (int j = 6; j <= 13; j++) begin
         tick();
         n_checks++;
         if ({bus.sd_clk, bus.running, bus.sd_clk_fall, bus.sd_clk_rise} !==
             {j < 8, j < 8, j == 8, 1'b0}) begin
            n_fail++;
            $display("FAIL stop_high cycle %0d got clk/run/fall/rise=%b want %b", j,
                     {bus.sd_clk, bus.running, bus.sd_clk_fall, bus.sd_clk_rise},
                     {j < 8, j < 8, j == 8, 1'b0});
         end
      end
   endtask

   task automatic test_div_switch();
      start_run(16'd3);
      for (int j = 1; j <= 5; j++) tick();
      bus.div_wr  = 1'b1;
      bus.div_val = 16'd0;
      tick();
      bus.div_wr = 1'b0;
      tick();
      n_checks++;
      if ({bus.div_pending, bus.div_cur} !== {1'b1, 16'd3}) begin
         n_fail++;
         $display("FAIL switch_pending got pend=%b div=%0d want pend=1 div=3",
                  bus.div_pending, bus.div_cur);
      end
      tick();
      n_checks++;
      if ({bus.div_pending, bus.div_cur, bus.sd_clk_fall} !== {1'b0, 16'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL switch_apply got pend=%b div=%0d fall=%b want pend=0 div=0 fall=1",
                  bus.div_pending, bus.div_cur, bus.sd_clk_fall);
      end
      for (int j = 9; j <= 14; j++) begin
         tick();
         n_checks++;
         if (bus.sd_clk !== logic'(j % 2)) begin
            n_fail++;
            $display("FAIL switch_fast cycle %0d got clk=%b want %b", j, bus.sd_clk, logic'(j % 2));
         end
      end
      bus.clk_en = 1'b0;
      tick();
      n_checks++;
      if ({bus.running, bus.sd_clk, bus.sd_clk_rise} !== 3'b000) begin
         n_fail++;
         $display("FAIL switch_stop got run/clk/rise=%b want 000",
                  {bus.running, bus.sd_clk, bus.sd_clk_rise});
      end
   endtask

   task automatic test_back_to_back();
      start_run(16'd3);
      for (int j = 1; j <= 5; j++) tick();
      bus.div_wr  = 1'b1;
      bus.div_val = 16'd5;
      tick();
      bus.div_val = 16'd1;
      tick();
      n_checks++;
      if ({bus.div_pending, bus.div_cur} !== {1'b1, 16'd3}) begin
         n_fail++;
         $display("FAIL b2b_hold got pend=%b div=%0d want pend=1 div=3", bus.div_pending, bus.div_cur);
      end
      bus.div_val = 16'd2;
      tick();
      bus.div_wr = 1'b0;
      n_checks++;
      if ({bus.div_pending, bus.div_cur, bus.sd_clk_fall} !== {1'b1, 16'd1, 1'b1}) begin
         n_fail++;
         $display("FAIL b2b_apply got pend=%b div=%0d fall=%b want pend=1 div=1 fall=1",
                  bus.div_pending, bus.div_cur, bus.sd_clk_fall);
      end
      tick();
      tick();
      n_checks++;
      if ({bus.sd_clk, bus.sd_clk_rise} !== 2'b11) begin
         n_fail++;
         $display("FAIL b2b_rise got clk/rise=%b want 11", {bus.sd_clk, bus.sd_clk_rise});
      end
      tick();
      tick();
      n_checks++;
      if ({bus.div_pending, bus.div_cur, bus.sd_clk} !== {1'b0, 16'd2, 1'b0}) begin
         n_fail++;
         $display("FAIL b2b_second got pend=%b div=%0d clk=%b want pend=0 div=2 clk=0",
                  bus.div_pending, bus.div_cur, bus.sd_clk);
      end
      bus.clk_en = 1'b0;
      tick();
      n_checks++;
      if (bus.running !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_stop got run=%b want 0", bus.running);
      end
   endtask

   task automatic test_reset_mid_high();
      start_run(16'd9);
      for (int j = 1; j <= 12; j++) tick();
      n_checks++;
      if (bus.sd_clk !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid_pre got clk=%b want 1", bus.sd_clk);
      end
      reset      = 1'b1;
      bus.clk_en = 1'b0;
      #1;
      n_checks++;
      if ({bus.sd_clk, bus.running, bus.div_pending, bus.div_cur, bus.init_done} !==
          {1'b0, 1'b0, 1'b0, 16'd124, EXP_INIT_DONE}) begin
         n_fail++;
         $display("FAIL rst_mid got clk=%b run=%b pend=%b div=%0d done=%b want 0 0 0 124 %b",
                  bus.sd_clk, bus.running, bus.div_pending, bus.div_cur, bus.init_done, EXP_INIT_DONE);
      end
      tick();
      reset = 1'b0;
      tick();
      tick();
      n_checks++;
      if ({bus.sd_clk, bus.running} !== 2'b00) begin
         n_fail++;
         $display("FAIL rst_mid_after got clk/run=%b want 00", {bus.sd_clk, bus.running});
      end
   endtask

`ifdef SD_CLK_INIT_SEQ_EN
   task automatic test_init_seq();
      int rises;
      bit done;
      rises = 0;
      done  = 1'b0;
      start_run(16'd1);
      bus.clk_en = 1'b0;
      n_checks++;
      if ({bus.running, bus.init_done, bus.div_cur} !== {1'b1, 1'b0, 16'd1}) begin
         n_fail++;
         $display("FAIL init_enter got run=%b done=%b div=%0d want 1 0 1",
                  bus.running, bus.init_done, bus.div_cur);
      end
      for (int j = 0; j < 400 && !done; j++) begin
         tick();
         if (bus.sd_clk_rise) rises++;
         if (!bus.running) done = 1'b1;
      end
      n_checks++;
      if (!done) begin
         n_fail++;
         $display("FAIL init_timeout got running=%b want 0 within 400 cycles", bus.running);
      end
      n_checks++;
      if ({rises, bus.init_done, bus.sd_clk} !== {32'd74, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL init_count got rises=%0d done=%b clk=%b want 74 1 0",
                  rises, bus.init_done, bus.sd_clk);
      end
      for (int j = 0; j < 10; j++) begin
         tick();
         if (bus.sd_clk_rise) rises++;
      end
      n_checks++;
      if (rises !== 74) begin
         n_fail++;
         $display("FAIL init_quiet got rises=%0d want 74", rises);
      end
   endtask
`endif

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
`ifdef SD_CLK_INIT_SEQ_EN
      test_init_seq();
`endif
      test_run();
      test_stop_high();
      test_div_switch();
      test_back_to_back();
      test_reset_mid_high();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
